// File: rtl/mmio_game_periph_pkg.sv
// Shared constants for the Gambling Tec game-I/O peripheral: register offsets,
// LFSR taps, control/status bit positions and the LFSR step function.
package gt_mmio_pkg;

    localparam logic [4:0] OFF_RAND     = 5'h00;
    localparam logic [4:0] OFF_BTN_FLG  = 5'h04;
    localparam logic [4:0] OFF_LED      = 5'h08;
    localparam logic [4:0] OFF_TMR_CTRL = 5'h0C;
    localparam logic [4:0] OFF_TMR_CNT  = 5'h10;
    localparam logic [4:0] OFF_TMR_CMP  = 5'h14;
    localparam logic [4:0] OFF_STATUS   = 5'h18;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_CLR       = 1;
    localparam int STATUS_TMR_HIT = 0;

    // Galois right-shift step; the taps fold back in when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/mmio_game_periph_if.sv
// Data-memory bus between the core (master) and the peripheral (slave).
interface mmio_game_periph_if;

    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        hit_o;

    modport master (output mem_write_i, addr_i, wdata_i, input rdata_o, hit_o);
    modport slave  (input mem_write_i, addr_i, wdata_i, output rdata_o, hit_o);

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for one raw button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/mmio_game_periph.sv
// Game I/O responder on the core's load/store bus: LFSR random source, sticky
// button flags, LED register and a prescaled timer with compare flag.
module mmio_game_periph
    import gt_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2345,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned N_BTN     = 4,
    parameter int unsigned N_LED     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_game_periph_if.slave    bus,
    input  logic [N_BTN-1:0]     btn_i,
    output logic [N_LED-1:0]     led_o
);

    localparam int unsigned     PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    logic             hit;
    logic [4:0]       off;
    logic             wr;
    logic             wr_rand, wr_btn, wr_led, wr_ctrl, wr_cmp, wr_status;
    logic             unused_addr_lsb;

    logic [31:0]      rand_q;
    logic [N_BTN-1:0] btn_flg;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_clr;
    logic [N_LED-1:0] led_q;
    logic             tmr_en;
    logic [PW-1:0]    presc;
    logic [31:0]      tmr_cnt;
    logic [31:0]      tmr_cmp;
    logic             tmr_hit;

    logic             tick;
    logic             tmr_clr;
    logic [31:0]      cnt_inc;
    logic             hit_set;
    logic             hit_clr;
    logic [31:0]      rdata;

    assign hit = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
    assign off = {bus.addr_i[4:2], 2'b00};
    assign wr  = bus.mem_write_i && hit;
    assign unused_addr_lsb = ^bus.addr_i[1:0];

    assign wr_rand   = wr && (off == OFF_RAND);
    assign wr_btn    = wr && (off == OFF_BTN_FLG);
    assign wr_led    = wr && (off == OFF_LED);
    assign wr_ctrl   = wr && (off == OFF_TMR_CTRL);
    assign wr_cmp    = wr && (off == OFF_TMR_CMP);
    assign wr_status = wr && (off == OFF_STATUS);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_i[i]),
            .rise (btn_rise[i])
        );
    end

    assign btn_clr = wr_btn ? bus.wdata_i[N_BTN-1:0] : '0;
    assign tick    = tmr_en && (presc == PRE_LAST);
    assign tmr_clr = wr_ctrl && bus.wdata_i[CTRL_CLR];
    assign cnt_inc = tmr_cnt + 32'd1;
    // Compare against the pre-edge CMP so a CMP write only affects later steps.
    assign hit_set = tick && !tmr_clr && (cnt_inc == tmr_cmp);
    assign hit_clr = wr_status && bus.wdata_i[STATUS_TMR_HIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rand_q  <= LFSR_SEED;
            btn_flg <= '0;
            led_q   <= '0;
            tmr_en  <= 1'b0;
            presc   <= '0;
            tmr_cnt <= '0;
            tmr_cmp <= '1;
            tmr_hit <= 1'b0;
        end else begin
            if (wr_rand) rand_q <= (bus.wdata_i == 32'h0) ? LFSR_SEED : bus.wdata_i;
            else         rand_q <= lfsr_next(rand_q);

            // Set terms are OR-ed after the clear mask, so a same-cycle set wins.
            btn_flg <= btn_rise | (btn_flg & ~btn_clr);
            tmr_hit <= hit_set | (tmr_hit & ~hit_clr);

            if (wr_led)  led_q   <= bus.wdata_i[N_LED-1:0];
            if (wr_ctrl) tmr_en  <= bus.wdata_i[CTRL_EN];
            if (wr_cmp)  tmr_cmp <= bus.wdata_i;

            if (tmr_clr) begin
                presc   <= '0;
                tmr_cnt <= '0;
            end else if (tmr_en) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) tmr_cnt <= cnt_inc;
            end
        end
    end

    // NOTE: rdata gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        rdata = 32'h0;
        unique case (off)
            OFF_RAND:     rdata = rand_q;
            OFF_BTN_FLG:  rdata = 32'(btn_flg);
            OFF_LED:      rdata = 32'(led_q);
            OFF_TMR_CTRL: rdata = {31'h0, tmr_en};
            OFF_TMR_CNT:  rdata = tmr_cnt;
            OFF_TMR_CMP:  rdata = tmr_cmp;
            OFF_STATUS:   rdata = {31'h0, tmr_hit};
            default:      rdata = 32'h0;
        endcase
    end

    assign bus.rdata_o = hit ? rdata : 32'h0;
    assign bus.hit_o   = hit;
    assign led_o       = led_q;

endmodule

// File: tb/tb_mmio_game_periph.sv
// Self-checking bench for mmio_game_periph: directed scenarios plus a randomized
// register run compared against a cycle-level reference of the register map.
module tb_mmio_game_periph;

    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] SEED = 32'hACE1_2345;
    localparam int          TDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_i = 4'h0;
    logic [7:0] led_o;
    int         errors = 0;
    int         checks = 0;

    mmio_game_periph_if bus ();

    mmio_game_periph #(
        .BASE_ADDR (BASE),
        .LFSR_SEED (SEED),
        .TICK_DIV  (TDIV),
        .N_BTN     (4),
        .N_LED     (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .btn_i (btn_i),
        .led_o (led_o)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference random sequence straight from the register description.
    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        return q[0] ? ((q >> 1) ^ 32'h8020_0003) : (q >> 1);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.mem_write_i = 1'b0;
        bus.addr_i      = 32'h0;
        bus.wdata_i     = 32'h0;
    endtask

    task automatic wr_setup(input logic [31:0] a, input logic [31:0] d);
        bus.mem_write_i = 1'b1;
        bus.addr_i      = a;
        bus.wdata_i     = d;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        step();
        wr_setup(a, d);
        step();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a;
        #1;
        d = bus.rdata_o;
    endtask

    task automatic do_reset();
        idle();
        btn_i = 4'h0;
        rst   = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] exp_zero [3];
        exp_zero = '{32'h40C, 32'h410, 32'h418};
        do_reset();
        #1;
        checks++;
        if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led_o); end
        rd(BASE, d);
        checks++;
        if (d !== SEED) begin errors++; $display("FAIL reset_rand: got %h want %h", d, SEED); end
        checks++;
        if (bus.hit_o !== 1'b1) begin errors++; $display("FAIL reset_hit: got %b want 1", bus.hit_o); end
        foreach (exp_zero[i]) begin
            rd(exp_zero[i], d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_reg_%h: got %h want 0", exp_zero[i], d); end
        end
        rd(BASE + 32'h14, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp: got %h want ffffffff", d); end
        step();
        rd(BASE, d);
        checks++;
        if (d !== lfsr_step(SEED)) begin errors++; $display("FAIL rand_first_step: got %h want %h", d, lfsr_step(SEED)); end
    endtask

    task automatic test_led();
        logic [31:0] d;
        write_reg(BASE + 32'h8, 32'hFFFF_FF5A);
        #1;
        checks++;
        if (led_o !== 8'h5A) begin errors++; $display("FAIL led_out: got %h want 5a", led_o); end
        rd(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL led_read: got %h want 5a", d); end
        rd(32'h3FC, d);
        checks++;
        if (bus.hit_o !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL below_window: hit %b data %h want hit 0 data 0", bus.hit_o, d);
        end
        rd(32'h420, d);
        checks++;
        if (bus.hit_o !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL above_window: hit %b data %h want hit 0 data 0", bus.hit_o, d);
        end
    endtask

    task automatic test_btn();
        logic [31:0] d;
        logic [3:0]  m;
        do_reset();
        step();
        btn_i[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            rd(BASE + 32'h4, d);
            checks++;
            if (d !== ((k >= 3) ? 32'h4 : 32'h0)) begin
                errors++; $display("FAIL btn_rise_k%0d: got %h want %h", k, d, (k >= 3) ? 32'h4 : 32'h0);
            end
        end
        write_reg(BASE + 32'h4, 32'h4);
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'h4, d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL btn_held_clear_%0d: got %h want 0", k, d); end
            step();
        end
        btn_i[1] = 1'b1;
        step();
        step();
        wr_setup(BASE + 32'h4, 32'hF);
        step();
        idle();
        rd(BASE + 32'h4, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL btn_set_wins: got %h want 2", d); end
        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            btn_i = 4'h0;
            repeat (3) step();
            write_reg(BASE + 32'h4, 32'hF);
            btn_i = m;
            repeat (3) step();
            rd(BASE + 32'h4, d);
            checks++;
            if (d !== {28'h0, m}) begin errors++; $display("FAIL btn_random_%0d: got %h want %h", r, d, m); end
        end
        btn_i = 4'h0;
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] s;
        do_reset();
        write_reg(BASE + 32'h14, 32'h3);
        wr_setup(BASE + 32'hC, 32'h1);
        step();
        idle();
        for (int n = 0; n <= 12; n++) begin
            if (n > 0) step();
            rd(BASE + 32'h10, d);
            rd(BASE + 32'h18, s);
            checks++;
            if (d !== 32'(n / TDIV) || s !== ((n == 12) ? 32'h1 : 32'h0)) begin
                errors++; $display("FAIL timer_n%0d: cnt %h status %h want cnt %h status %0d",
                                   n, d, s, n / TDIV, n == 12);
            end
        end
        wr_setup(BASE + 32'h18, 32'h1);
        step();
        idle();
        rd(BASE + 32'h18, s);
        rd(BASE + 32'h10, d);
        checks++;
        if (s !== 32'h0 || d !== 32'h3) begin errors++; $display("FAIL status_w1c: status %h cnt %h want 0 and 3", s, d); end
        step();
        step();
        wr_setup(BASE + 32'hC, 32'h3);
        step();
        idle();
        rd(BASE + 32'h10, d);
        rd(BASE + 32'hC, s);
        checks++;
        if (d !== 32'h0 || s !== 32'h1) begin errors++; $display("FAIL clr_on_inc: cnt %h ctrl %h want 0 and 1", d, s); end
        for (int n = 17; n <= 21; n++) begin
            step();
            rd(BASE + 32'h10, d);
            checks++;
            if (d !== ((n >= 20) ? 32'h1 : 32'h0)) begin errors++; $display("FAIL after_clr_n%0d: got %h", n, d); end
        end
        wr_setup(BASE + 32'hC, 32'h3);
        for (int n = 22; n <= 26; n++) begin
            step();
            idle();
            rd(BASE + 32'h10, d);
            checks++;
            if (d !== ((n >= 26) ? 32'h1 : 32'h0)) begin errors++; $display("FAIL presc_clr_n%0d: got %h", n, d); end
        end
        write_reg(BASE + 32'hC, 32'h0);
        for (int k = 0; k < 6; k++) begin
            rd(BASE + 32'h10, d);
            rd(BASE + 32'hC, s);
            checks++;
            if (d !== 32'h1 || s !== 32'h0) begin errors++; $display("FAIL freeze_%0d: cnt %h ctrl %h want 1 and 0", k, d, s); end
            step();
        end
        write_reg(BASE + 32'hC, 32'h1);
        for (int k = 0; k < 3; k++) begin
            rd(BASE + 32'h10, d);
            checks++;
            if (d !== ((k == 2) ? 32'h2 : 32'h1)) begin errors++; $display("FAIL resume_%0d: got %h", k, d); end
            step();
        end
    endtask

    task automatic test_rand_write();
        logic [31:0] d;
        logic [31:0] v;
        write_reg(BASE, 32'h0);
        rd(BASE, d);
        checks++;
        if (d !== SEED) begin errors++; $display("FAIL rand_zero_reseed: got %h want %h", d, SEED); end
        step();
        rd(BASE, d);
        checks++;
        if (d !== lfsr_step(SEED)) begin errors++; $display("FAIL rand_after_reseed: got %h want %h", d, lfsr_step(SEED)); end
        v = $urandom | 32'h1;
        write_reg(BASE, v);
        rd(BASE, d);
        checks++;
        if (d !== v) begin errors++; $display("FAIL rand_load: got %h want %h", d, v); end
    endtask

    task automatic test_random_regs();
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] v;
        logic [31:0] m_rand;
        logic [31:0] m_cmp;
        logic [7:0]  m_led;
        int          op;
        do_reset();
        m_rand = SEED;
        m_cmp  = 32'hFFFF_FFFF;
        m_led  = 8'h00;
        for (int c = 0; c < 300; c++) begin
            idle();
            rd(BASE + 32'($urandom_range(0, 3)), d);
            checks++;
            if (d !== m_rand) begin errors++; $display("FAIL rnd_rand_c%0d: got %h want %h", c, d, m_rand); end
            rd(BASE + 32'h8, d);
            checks++;
            if (d !== {24'h0, m_led} || led_o !== m_led) begin
                errors++; $display("FAIL rnd_led_c%0d: read %h pins %h want %h", c, d, led_o, m_led);
            end
            rd(BASE + 32'h14, d);
            checks++;
            if (d !== m_cmp) begin errors++; $display("FAIL rnd_cmp_c%0d: got %h want %h", c, d, m_cmp); end
            rd(BASE + 32'h10, d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL rnd_cnt_c%0d: got %h want 0", c, d); end
            op = $urandom_range(0, 5);
            v  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            case (op)
                0: wr_setup(BASE + 32'($urandom_range(0, 3)), v);
                1: wr_setup(BASE + 32'h8 + 32'($urandom_range(0, 3)), v);
                2: wr_setup(BASE + 32'h14 + 32'($urandom_range(0, 3)), v);
                3: begin
                    a = $urandom;
                    if (a[31:5] == BASE[31:5]) a = a ^ 32'h8000_0000;
                    wr_setup(a, v);
                    #1;
                    checks++;
                    if (bus.hit_o !== 1'b0 || bus.rdata_o !== 32'h0) begin
                        errors++; $display("FAIL rnd_outside_c%0d: addr %h hit %b data %h want 0/0", c, a, bus.hit_o, bus.rdata_o);
                    end
                end
                4: wr_setup(BASE + (($urandom_range(0, 1) == 0) ? 32'h10 : 32'h1C), v);
                default: idle();
            endcase
            if (op == 0) m_rand = (v == 32'h0) ? SEED : v;
            else         m_rand = lfsr_step(m_rand);
            if (op == 1) m_led = v[7:0];
            if (op == 2) m_cmp = v;
            step();
        end
        idle();
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        do_reset();
        write_reg(BASE + 32'h8, 32'h5A);
        write_reg(BASE + 32'hC, 32'h1);
        repeat (6) step();
        rd(BASE + 32'h10, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL pre_reset_cnt: got %h want 1", d); end
        wr_setup(BASE + 32'h8, 32'hFF);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (led_o !== 8'h00) begin errors++; $display("FAIL async_led: got %h want 00", led_o); end
        idle();
        rd(BASE + 32'h10, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL async_cnt: got %h want 0", d); end
        rd(BASE, d);
        checks++;
        if (d !== SEED) begin errors++; $display("FAIL async_rand: got %h want %h", d, SEED); end
        wr_setup(BASE + 32'h8, 32'hFF);
        step();
        step();
        idle();
        rst = 1'b1;
        rd(BASE + 32'h8, d);
        checks++;
        if (d !== 32'h0 || led_o !== 8'h00) begin errors++; $display("FAIL no_pending_write: read %h pins %h want 0", d, led_o); end
        rd(BASE + 32'hC, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
    endtask

    initial begin
        idle();
        test_reset();
        test_led();
        test_btn();
        test_timer();
        test_rand_write();
        test_random_regs();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
